// File: rtl/axi_lite_dmem_slave.sv
// AXI4-Lite data-memory responder: byte-strobed word RAM, range decode with SLVERR.
// Latency: BVALID the cycle after commit; RVALID RD_LATENCY cycles after the AR handshake.
// Backpressure: one outstanding transaction per channel; BVALID/RVALID held until READY.
module axi_lite_dmem_slave #(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          RD_LATENCY  = 1
) (
   input  logic        CLK,
   input  logic        NRST,
   input  logic [31:0] AXI_AWADDR,
   input  logic        AXI_AWVALID,
   output logic        AXI_AWREADY,
   input  logic [31:0] AXI_WDATA,
   input  logic [3:0]  AXI_WSTRB,
   input  logic        AXI_WVALID,
   output logic        AXI_WREADY,
   output logic [1:0]  AXI_BRESP,
   output logic        AXI_BVALID,
   input  logic        AXI_BREADY,
   input  logic [31:0] AXI_ARADDR,
   input  logic        AXI_ARVALID,
   output logic        AXI_ARREADY,
   output logic [31:0] AXI_RDATA,
   output logic [1:0]  AXI_RRESP,
   output logic        AXI_RVALID,
   input  logic        AXI_RREADY
);

   localparam int          IDX_W  = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN   = 32'(DEPTH_WORDS * 4);
   localparam logic [3:0]  LAT_M1 = 4'(RD_LATENCY - 1);
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

   logic [31:0] mem [DEPTH_WORDS];

   w_state_e    w_state_q, w_state_d;
   logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;

   r_state_e    r_state_q, r_state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;
   logic        arready_q, arready_d, rvalid_q, rvalid_d;

   logic        aw_hs, w_hs, ar_hs, commit;
   logic [31:0] c_addr, c_data, w_off, r_off;
   logic [3:0]  c_strb;
   logic        w_in, r_in;
   logic [IDX_W-1:0] w_idx, r_idx;

   assign aw_hs = AXI_AWVALID & awready_q;
   assign w_hs  = AXI_WVALID & wready_q;
   assign ar_hs = AXI_ARVALID & arready_q;

   // Subtracting the base makes addresses below BASE_ADDR wrap to large offsets,
   // so a single unsigned compare covers both ends of the window.
   assign w_off = c_addr - BASE_ADDR;
   assign w_in  = w_off < SPAN;
   assign w_idx = w_off[IDX_W+1:2];
   assign r_off = AXI_ARADDR - BASE_ADDR;
   assign r_in  = r_off < SPAN;
   assign r_idx = r_off[IDX_W+1:2];

   // Commit operands: live bus values, or whichever half was latched earlier.
   always_comb begin
      c_addr = AXI_AWADDR;
      c_data = AXI_WDATA;
      c_strb = AXI_WSTRB;
      if (w_state_q == W_WAIT_DATA) c_addr = awaddr_q;
      if (w_state_q == W_WAIT_ADDR) begin
         c_data = wdata_q;
         c_strb = wstrb_q;
      end
   end

   // Write FSM next state, latches and registered-output next values.
   always_comb begin
      w_state_d = w_state_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bresp_d   = bresp_q;
      commit    = 1'b0;
      unique case (w_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit    = 1'b1;
               w_state_d = W_RESP;
            end else if (aw_hs) begin
               awaddr_d  = AXI_AWADDR;
               w_state_d = W_WAIT_DATA;
            end else if (w_hs) begin
               wdata_d   = AXI_WDATA;
               wstrb_d   = AXI_WSTRB;
               w_state_d = W_WAIT_ADDR;
            end
         end
         W_WAIT_DATA: if (w_hs) begin
            commit    = 1'b1;
            w_state_d = W_RESP;
         end
         W_WAIT_ADDR: if (aw_hs) begin
            commit    = 1'b1;
            w_state_d = W_RESP;
         end
         W_RESP: if (AXI_BREADY && bvalid_q) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
      if (commit) bresp_d = w_in ? OKAY : SLVERR;
      awready_d = (w_state_d == W_IDLE) || (w_state_d == W_WAIT_ADDR);
      wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_WAIT_DATA);
      bvalid_d  = (w_state_d == W_RESP);
   end

   // Write FSM state and registered outputs.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         w_state_q <= W_IDLE;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bresp_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bresp_q   <= bresp_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
      end
   end

   // RAM byte-lane write on the commit edge; contents deliberately survive reset.
   always_ff @(posedge CLK) begin
      if (commit && w_in) begin
         for (int b = 0; b < 4; b++) begin
            if (c_strb[b]) mem[w_idx][8*b +: 8] <= c_data[8*b +: 8];
         end
      end
   end

   // Read FSM: data sampled at the AR handshake, then delayed by the latency counter.
   always_comb begin
      r_state_d = r_state_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      unique case (r_state_q)
         R_IDLE: if (ar_hs) begin
            rdata_d = r_in ? mem[r_idx] : 32'h0;
            rresp_d = r_in ? OKAY : SLVERR;
            if (RD_LATENCY == 1) begin
               r_state_d = R_DATA;
            end else begin
               r_state_d = R_WAIT;
               cnt_d     = LAT_M1;
            end
         end
         R_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) r_state_d = R_DATA;
         end
         R_DATA: if (AXI_RREADY && rvalid_q) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
      arready_d = (r_state_d == R_IDLE);
      rvalid_d  = (r_state_d == R_DATA);
   end

   // Read FSM state and registered outputs.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         r_state_q <= R_IDLE;
         cnt_q     <= '0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         cnt_q     <= cnt_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
      end
   end

   assign AXI_AWREADY = awready_q;
   assign AXI_WREADY  = wready_q;
   assign AXI_BRESP   = bresp_q;
   assign AXI_BVALID  = bvalid_q;
   assign AXI_ARREADY = arready_q;
   assign AXI_RDATA   = rdata_q;
   assign AXI_RRESP   = rresp_q;
   assign AXI_RVALID  = rvalid_q;

endmodule

// File: tb/tb_axi_lite_dmem_slave.sv
// Directed bench for axi_lite_dmem_slave: a latency-1 instance and a latency-4 instance
// sharing the write channel, so both RAMs hold identical contents.
// Inputs change and outputs are checked on the falling edge.
module tb_axi_lite_dmem_slave;
   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
   logic [3:0]  wstrb = '0;
   logic        awvalid = 0, wvalid = 0, bready = 0;
   logic        arvalid = 0, rready = 0, arvalid2 = 0, rready2 = 0;

   logic        aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
   logic [1:0]  b_resp, r_resp;
   logic [31:0] r_dat;
   logic        aw2_rdy, w2_rdy, b2_vld, ar2_rdy, r2_vld;
   logic [1:0]  b2_resp, r2_resp;
   logic [31:0] r2_dat;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   axi_lite_dmem_slave #(.RD_LATENCY(1)) dut (
      .CLK(clk), .NRST(nrst),
      .AXI_AWADDR(awaddr), .AXI_AWVALID(awvalid), .AXI_AWREADY(aw_rdy),
      .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid), .AXI_WREADY(w_rdy),
      .AXI_BRESP(b_resp), .AXI_BVALID(b_vld), .AXI_BREADY(bready),
      .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid), .AXI_ARREADY(ar_rdy),
      .AXI_RDATA(r_dat), .AXI_RRESP(r_resp), .AXI_RVALID(r_vld), .AXI_RREADY(rready));

   axi_lite_dmem_slave #(.RD_LATENCY(4)) dut4 (
      .CLK(clk), .NRST(nrst),
      .AXI_AWADDR(awaddr), .AXI_AWVALID(awvalid), .AXI_AWREADY(aw2_rdy),
      .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid), .AXI_WREADY(w2_rdy),
      .AXI_BRESP(b2_resp), .AXI_BVALID(b2_vld), .AXI_BREADY(bready),
      .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid2), .AXI_ARREADY(ar2_rdy),
      .AXI_RDATA(r2_dat), .AXI_RRESP(r2_resp), .AXI_RVALID(r2_vld), .AXI_RREADY(rready2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // AW and W presented together, then the B handshake.
   task automatic wr_same(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] exp_resp);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
      chk({tag, ".awready"}, 32'(aw_rdy), 32'd1);
      tick();
      awvalid = 0; wvalid = 0;
      chk({tag, ".bvalid"}, 32'(b_vld), 32'd1);
      chk({tag, ".bresp"}, 32'(b_resp), 32'(exp_resp));
      bready = 1;
      tick();
      bready = 0;
      chk({tag, ".bvalid_clr"}, 32'(b_vld), 32'd0);
      chk({tag, ".ready_back"}, 32'({aw_rdy, w_rdy}), 32'd3);
   endtask

   // Latency-1 read on the first instance.
   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                     input logic [1:0] exp_resp);
      araddr = a; arvalid = 1;
      chk({tag, ".arready"}, 32'(ar_rdy), 32'd1);
      tick();
      arvalid = 0;
      chk({tag, ".rvalid"}, 32'(r_vld), 32'd1);
      chk({tag, ".rdata"}, r_dat, exp_d);
      chk({tag, ".rresp"}, 32'(r_resp), 32'(exp_resp));
      rready = 1;
      tick();
      rready = 0;
      chk({tag, ".rvalid_clr"}, 32'(r_vld), 32'd0);
   endtask

   initial begin
      // Reset state
      tick();
      chk("rst.readies", 32'({aw_rdy, w_rdy, ar_rdy, ar2_rdy}), 32'd0);
      chk("rst.valids", 32'({b_vld, r_vld, b2_vld, r2_vld}), 32'd0);
      chk("rst.resp", 32'({b_resp, r_resp}), 32'd0);
      chk("rst.rdata", r_dat, 32'd0);
      nrst = 1;
      tick();
      chk("post_rst.readies", 32'({aw_rdy, w_rdy, ar_rdy, ar2_rdy}), 32'hF);

      // Same-cycle write then readback
      wr_same("w_same", 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00);
      rd("r_same", 32'h1000_0010, 32'hDEAD_BEEF, 2'b00);

      // W three cycles ahead of AW, single-lane strobe
      wdata = 32'h0000_AB00; wstrb = 4'b0010; wvalid = 1;
      tick();
      wvalid = 0;
      chk("wfirst.rdy", 32'({aw_rdy, w_rdy}), 32'b10);
      tick();
      tick();
      chk("wfirst.nob", 32'(b_vld), 32'd0);
      awaddr = 32'h1000_0010; awvalid = 1;
      tick();
      awvalid = 0;
      chk("wfirst.bvalid", 32'(b_vld), 32'd1);
      chk("wfirst.bresp", 32'(b_resp), 32'd0);
      bready = 1;
      tick();
      bready = 0;
      rd("r_strb", 32'h1000_0010, 32'hDEAD_ABEF, 2'b00);

      // AW ahead of W: word at 0x20 = 0x11
      awaddr = 32'h1000_0020; awvalid = 1;
      tick();
      awvalid = 0;
      chk("awfirst.rdy", 32'({aw_rdy, w_rdy}), 32'b01);
      tick();
      wdata = 32'h0000_0011; wstrb = 4'hF; wvalid = 1;
      tick();
      wvalid = 0;
      chk("awfirst.bvalid", 32'(b_vld), 32'd1);
      chk("awfirst.bresp", 32'(b_resp), 32'd0);
      bready = 1;
      tick();
      bready = 0;

      // Range decode: word 0, last word, one past the end, below the base
      wr_same("w_word0", 32'h1000_0000, 32'hA5A5_A5A5, 4'hF, 2'b00);
      wr_same("w_last", 32'h1000_0FFC, 32'hCAFE_F00D, 4'hF, 2'b00);
      wr_same("w_oor", 32'h1000_1000, 32'h1234_5678, 4'hF, 2'b10);
      rd("r_word0", 32'h1000_0000, 32'hA5A5_A5A5, 2'b00);
      rd("r_last", 32'h1000_0FFF, 32'hCAFE_F00D, 2'b00);
      rd("r_below", 32'h0FFF_FFFC, 32'h0, 2'b10);
      rd("r_past", 32'h1000_1000, 32'h0, 2'b10);
      wr_same("w_nostrb", 32'h1000_0000, 32'hFFFF_FFFF, 4'h0, 2'b00);
      rd("r_nostrb", 32'h1000_0000, 32'hA5A5_A5A5, 2'b00);

      // Latency-4 instance with RREADY held low
      araddr = 32'h1000_0010; arvalid2 = 1;
      chk("lat4.arready", 32'(ar2_rdy), 32'd1);
      tick();
      arvalid2 = 0;
      for (int i = 0; i < 3; i++) begin
         chk("lat4.wait_rvalid", 32'(r2_vld), 32'd0);
         chk("lat4.wait_arready", 32'(ar2_rdy), 32'd0);
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         chk("lat4.rvalid", 32'(r2_vld), 32'd1);
         chk("lat4.rdata", r2_dat, 32'hDEAD_ABEF);
         chk("lat4.rresp", 32'(r2_resp), 32'd0);
         chk("lat4.arready_hold", 32'(ar2_rdy), 32'd0);
         tick();
      end
      rready2 = 1;
      tick();
      rready2 = 0;
      chk("lat4.rvalid_clr", 32'(r2_vld), 32'd0);
      chk("lat4.arready_back", 32'(ar2_rdy), 32'd1);

      // AR handshake on the same edge as a commit to that word: old data wins
      awaddr = 32'h1000_0020; wdata = 32'h0000_0055; wstrb = 4'hF;
      awvalid = 1; wvalid = 1;
      araddr = 32'h1000_0020; arvalid = 1;
      tick();
      awvalid = 0; wvalid = 0; arvalid = 0;
      chk("hazard.rvalid", 32'(r_vld), 32'd1);
      chk("hazard.rdata", r_dat, 32'h0000_0011);
      chk("hazard.bvalid", 32'(b_vld), 32'd1);
      rready = 1; bready = 1;
      tick();
      rready = 0; bready = 0;
      rd("r_after_hazard", 32'h1000_0020, 32'h0000_0055, 2'b00);

      // Reset asserted while a response is pending
      awaddr = 32'h1000_0030; wdata = 32'h600D_F00D; wstrb = 4'hF;
      awvalid = 1; wvalid = 1;
      tick();
      awvalid = 0; wvalid = 0;
      chk("rst_mid.bvalid", 32'(b_vld), 32'd1);
      #2 nrst = 0;
      #1;
      chk("rst_mid.bvalid_async", 32'(b_vld), 32'd0);
      chk("rst_mid.readies", 32'({aw_rdy, w_rdy, ar_rdy}), 32'd0);
      tick();
      chk("rst_mid.readies_held", 32'({aw_rdy, w_rdy, ar_rdy}), 32'd0);
      nrst = 1;
      tick();
      chk("rst_mid.readies_back", 32'({aw_rdy, w_rdy, ar_rdy}), 32'd7);
      chk("rst_mid.bvalid_idle", 32'(b_vld), 32'd0);
      rd("r_survive", 32'h1000_0030, 32'h600D_F00D, 2'b00);
      rd("r_survive_old", 32'h1000_0010, 32'hDEAD_ABEF, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/axi_lite_dmem_slave.md
Name: axi_lite_dmem_slave

Overview:
- AXI4-Lite responder (slave) that models the core's data memory; it is the memory-side end of the HOST_AXI read/write channels that the pipeline control drives as initiator.
- Word-organised synchronous RAM with byte strobes, range decode with SLVERR, and a programmable read latency so the core's stall path can be exercised.
- Write and read channels are independent; each allows one outstanding transaction.

Parameters:
- BASE_ADDR, 32'h1000_0000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 4.
- RD_LATENCY, 1, cycles from AR handshake to RVALID assertion; allowed range 1..15.

Ports:
- CLK  in  1  clock, rising edge.
- NRST  in  1  asynchronous active-low reset.
- AXI_AWADDR  in  32  write byte address.
- AXI_AWVALID  in  1  write address valid.
- AXI_AWREADY  out  1  write address ready.
- AXI_WDATA  in  32  write data.
- AXI_WSTRB  in  4  byte lane enables; bit i enables WDATA[8i+7:8i].
- AXI_WVALID  in  1  write data valid.
- AXI_WREADY  out  1  write data ready.
- AXI_BRESP  out  2  2'b00 OKAY, 2'b10 SLVERR.
- AXI_BVALID  out  1  write response valid.
- AXI_BREADY  in  1  write response ready.
- AXI_ARADDR  in  32  read byte address.
- AXI_ARVALID  in  1  read address valid.
- AXI_ARREADY  out  1  read address ready.
- AXI_RDATA  out  32  read data.
- AXI_RRESP  out  2  read response.
- AXI_RVALID  out  1  read data valid.
- AXI_RREADY  in  1  read data ready.

Behaviour:
- Reset: one clock (CLK); reset is asynchronous and active-low (NRST).
  - While NRST=0: all outputs are 0 and both FSMs go to IDLE.
  - All outputs are registered. AWREADY, WREADY and ARREADY rise on the first CLK edge after NRST deasserts.
  - The RAM array is not reset; its contents survive reset.
  - Reset mid-transaction abandons that transaction. A write is lost unless its commit edge has already occurred.
- Decode:
  - idx = (addr - BASE_ADDR) >> 2; addr[1:0] is ignored.
  - An address is in range when BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS, compared as unsigned 32-bit values.
  - Out-of-range write: the RAM is untouched and BRESP=2'b10.
  - Out-of-range read: RDATA=0 and RRESP=2'b10.
- Write FSM states: W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP.
  - W_IDLE, AWREADY=1, WREADY=1:
    - AW and W handshake in the same cycle: commit and go to W_RESP.
    - AW only: latch the address and go to W_WAIT_DATA.
    - W only: latch WDATA and WSTRB and go to W_WAIT_ADDR.
  - W_WAIT_DATA (WREADY=1, AWREADY=0): on W handshake, commit and go to W_RESP.
  - W_WAIT_ADDR (AWREADY=1, WREADY=0): on AW handshake, commit and go to W_RESP.
  - Commit: the RAM is written on the commit edge, only the lanes whose WSTRB bit is 1. WSTRB=0 commits nothing and still returns OKAY.
  - W_RESP: AWREADY=0 and WREADY=0. BVALID=1 from the cycle after the commit, with BRESP held stable until BREADY=1. Then go to W_IDLE and the readies return the next cycle.
- Read FSM states: R_IDLE, R_WAIT, R_DATA.
  - R_IDLE, ARREADY=1: on AR handshake, capture mem[idx] (or 0) and RRESP.
    - RD_LATENCY=1: go to R_DATA.
    - Otherwise: go to R_WAIT with counter = RD_LATENCY-1.
  - R_WAIT: ARREADY=0; decrement the counter each cycle; go to R_DATA when it reaches 0.
  - R_DATA: RVALID=1 and RDATA/RRESP held stable until RREADY=1, then go to R_IDLE.
  - RVALID first asserts exactly RD_LATENCY cycles after the AR handshake edge.
- Hazards and ordering:
  - Read data is sampled at the AR handshake.
  - A write committing on the same edge as the AR handshake is not visible to that read: it returns the old data.
  - Later writes never alter a captured RDATA.
  - Read and write channels progress concurrently, with no ordering between them.
- Protocol: VALID/READY from the master may toggle freely. The block never drops BVALID or RVALID before the corresponding READY handshake.

Test Plan:
- Reset, then AW 0x1000_0010 and W 0xDEADBEEF (strb 4'hF) in the same cycle → BVALID=1 one cycle later with BRESP=00. Then AR 0x1000_0010 → RVALID after 1 cycle with RDATA=0xDEADBEEF, RRESP=00.
- W 0x0000_AB00 (strb 4'b0010) presented 3 cycles before AW 0x1000_0010 → FSM passes through W_WAIT_ADDR, BRESP=00. A subsequent read returns 0xDEADABEF.
- AW 0x1000_1000 (one past the end) with W 0x12345678 → BRESP=10 and the RAM is unchanged. AR 0x0FFF_FFFC → RDATA=0, RRESP=10.
- RD_LATENCY=4, RREADY held 0 for 5 cycles → RVALID asserts 4 cycles after the AR handshake and RDATA stays stable until RREADY=1. ARREADY stays 0 throughout.
- Same-edge AR 0x1000_0020 and write commit of 0x55 to that address (old value 0x11) → RDATA=0x11. The next read returns 0x55.
- NRST pulsed low while in W_RESP → BVALID drops to 0 asynchronously and the readies are 0 during reset. After release the readies reassert, and the committed data is still readable.
